// File: rtl/mem_bus_arb.sv
// KS-10 memory bus arbiter/sequencer: grants CPU or console, runs one bus cycle, NXM on timeout.
// Optional build macro MEM_BUS_ARB_RR_EN selects round-robin tie-breaking (default: console wins ties).
module mem_bus_arb #(
    parameter int NXM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpuREQI,
    input  logic [0:35] cpuADDRI,
    input  logic [0:35] cpuDATAI,
    output logic        cpuACKO,
    output logic        cpuNXMO,
    output logic [0:35] cpuDATAO,
    input  logic        conREQI,
    input  logic [0:35] conADDRI,
    input  logic [0:35] conDATAI,
    output logic        conACKO,
    output logic        conNXMO,
    output logic [0:35] conDATAO,
    output logic        busREQO,
    output logic [0:35] busADDRO,
    output logic [0:35] busDATAO,
    input  logic        busACKI,
    input  logic [0:35] busDATAI
);
    localparam int M_CPU = 0;
    localparam int M_CON = 1;
    localparam logic [7:0] TMO_LAST = 8'(NXM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic             win_q, win_d;   // master of the current/last grant, 1 = console
    logic             nxm_q, nxm_d;
    logic             ta_q, ta_d;
    logic [0:35]      addr_q, addr_d;
    logic [0:35]      wdata_q, wdata_d;
    logic             rd_capture, rd_clear, grant_con;

    logic [1:0]       req_raw, req_elig, ack, nxm;
    logic [1:0][0:35] m_addr, m_wdata, m_rdata;

    assign req_raw = {conREQI, cpuREQI};
    assign m_addr  = {conADDRI, cpuADDRI};
    assign m_wdata = {conDATAI, cpuDATAI};

    // Per-master request masking, completion strobes and read-data holding registers.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            localparam logic MID = (gi == M_CON);
            logic [0:35] rdata_q;

            assign req_elig[gi] = req_raw[gi] & ~(ta_q & (win_q == MID));
            assign ack[gi]      = (state_q == ST_DONE) && (win_q == MID);
            assign nxm[gi]      = ack[gi] & nxm_q;
            assign m_rdata[gi]  = rdata_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                end else if (win_q == MID) begin
                    if (rd_capture) begin
                        rdata_q <= busDATAI;
                    end else if (rd_clear) begin
                        rdata_q <= '0;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        if (req_elig[M_CON] && req_elig[M_CPU]) begin
`ifdef MEM_BUS_ARB_RR_EN
            grant_con = ~win_q;
`else
            grant_con = 1'b1;
`endif
        end else begin
            grant_con = req_elig[M_CON];
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        win_d      = win_q;
        nxm_d      = nxm_q;
        ta_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_capture = 1'b0;
        rd_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_elig) begin
                    win_d   = grant_con;
                    addr_d  = grant_con ? m_addr[M_CON]  : m_addr[M_CPU];
                    wdata_d = grant_con ? m_wdata[M_CON] : m_wdata[M_CPU];
                    timer_d = 8'd0;
                    nxm_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ACK on the final timer cycle still counts as a hit.
                if (busACKI) begin
                    rd_capture = addr_q[3];
                    nxm_d      = 1'b0;
                    state_d    = ST_DONE;
                end else if (timer_q == TMO_LAST) begin
                    rd_clear = 1'b1;
                    nxm_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            ST_DONE: begin
                ta_d    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= 8'd0;
            win_q   <= 1'b1;
            nxm_q   <= 1'b0;
            ta_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            win_q   <= win_d;
            nxm_q   <= nxm_d;
            ta_q    <= ta_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign busREQO  = (state_q == ST_WAIT);
    assign busADDRO = addr_q;
    assign busDATAO = wdata_q;

    assign cpuACKO  = ack[M_CPU];
    assign cpuNXMO  = nxm[M_CPU];
    assign cpuDATAO = m_rdata[M_CPU];
    assign conACKO  = ack[M_CON];
    assign conNXMO  = nxm[M_CON];
    assign conDATAO = m_rdata[M_CON];
endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb: per-cycle vector table plus sequences for timeout, ties,
// mid-cycle reset and mid-WAIT request drop.
module tb_mem_bus_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        cpuREQI, conREQI, busACKI;
    logic [0:35] cpuADDRI, cpuDATAI, conADDRI, conDATAI, busDATAI;
    logic        cpuACKO, cpuNXMO, conACKO, conNXMO, busREQO;
    logic [0:35] cpuDATAO, conDATAO, busADDRO, busDATAO;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MEM_BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_bus_arb #(.NXM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cpuREQI(cpuREQI), .cpuADDRI(cpuADDRI), .cpuDATAI(cpuDATAI),
        .cpuACKO(cpuACKO), .cpuNXMO(cpuNXMO), .cpuDATAO(cpuDATAO),
        .conREQI(conREQI), .conADDRI(conADDRI), .conDATAI(conDATAI),
        .conACKO(conACKO), .conNXMO(conNXMO), .conDATAO(conDATAO),
        .busREQO(busREQO), .busADDRO(busADDRO), .busDATAO(busDATAO),
        .busACKI(busACKI), .busDATAI(busDATAI)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        cpu_req, con_req, ack;
        logic [0:35] cpu_addr, cpu_wd, con_addr, con_wd, bus_rd;
        logic        e_busreq;
        logic [0:35] e_busaddr, e_busdata;
        logic        e_cpuack, e_cpunxm;
        logic [0:35] e_cpudata;
        logic        e_conack, e_connxm;
        logic [0:35] e_condata;
    } vec_t;

    vec_t vecs[$];
    logic [0:35] z, a1, a2, a3, a_to, d1, d3, d6, w777, cw, junk;

    function automatic logic [0:35] mk(input logic rd, input logic wr, input logic [0:35] adr);
        logic [0:35] r;
        r    = adr;
        r[3] = rd;
        r[5] = wr;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %o, expected %o", nm, act, exp);
        end
    endtask

    // Runs a request pattern with MEM acking at once; masters drop REQ the cycle after their ACKO.
    task automatic run_req(input string nm, input logic rq_cpu, input logic rq_con,
                           input int exp_cpu, input int exp_con);
        int cpu_edge, con_edge, cpu_n, con_n;
        logic cpu_drop, con_drop;
        logic [0:35] exp_addr;
        cpu_edge = 0; con_edge = 0; cpu_n = 0; con_n = 0;
        cpu_drop = 1'b0; con_drop = 1'b0;
        exp_addr = (exp_con == 2) ? a3 : a1;
        cpuREQI  = rq_cpu;
        conREQI  = rq_con;
        cpuADDRI = a1;
        conADDRI = a3;
        busACKI  = 1'b1;
        busDATAI = 36'o1111;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (cpu_drop) cpuREQI = 1'b0;
            if (con_drop) conREQI = 1'b0;
            if (e == 1) check({nm, " grant addr"}, busADDRO, exp_addr);
            if (cpuACKO) begin
                cpu_n++;
                if (cpu_edge == 0) cpu_edge = e;
                cpu_drop = 1'b1;
            end
            if (conACKO) begin
                con_n++;
                if (con_edge == 0) con_edge = e;
                con_drop = 1'b1;
            end
        end
        busACKI = 1'b0;
        check({nm, " cpu ack edge"}, 36'(cpu_edge), 36'(exp_cpu));
        check({nm, " con ack edge"}, 36'(con_edge), 36'(exp_con));
        check({nm, " cpu ack count"}, 36'(cpu_n), {35'd0, rq_cpu});
        check({nm, " con ack count"}, 36'(con_n), {35'd0, rq_con});
        $display("seq %s: cpu ack edge %0d, con ack edge %0d", nm, cpu_edge, con_edge);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ack_e, wait_n, n;
        logic nxm_seen;
        logic [0:35] dat;

        z    = '0;
        a1   = mk(1'b1, 1'b0, 36'o1000);
        a2   = mk(1'b0, 1'b1, 36'o2000);
        a3   = mk(1'b1, 1'b0, 36'o4000);
        a_to = mk(1'b1, 1'b0, 36'o100000);
        d1   = 36'o123456;
        d3   = 36'o4321;
        d6   = 36'o7070;
        w777 = 36'o777;
        cw   = 36'o11;
        junk = 36'o555555;

        // name, cpu_req, con_req, ack, cpu_addr, cpu_wd, con_addr, con_wd, bus_rd,
        // e_busreq, e_busaddr, e_busdata, e_cpuack, e_cpunxm, e_cpudata, e_conack, e_connxm, e_condata
        vecs.push_back('{"t1 req",    1'b1, 1'b0, 1'b0, a1, z, z, z, z,    1'b1, a1, z, 1'b0, 1'b0, z,  1'b0, 1'b0, z});
        vecs.push_back('{"t1 ack",    1'b1, 1'b0, 1'b1, a1, z, z, z, d1,   1'b0, a1, z, 1'b1, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t1 done",   1'b1, 1'b0, 1'b0, a1, z, z, z, z,    1'b0, a1, z, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t1 stale",  1'b1, 1'b0, 1'b0, a1, z, z, z, z,    1'b0, a1, z, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t1 idle",   1'b0, 1'b0, 1'b0, z,  z, z, z, z,    1'b0, a1, z, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t2 req",    1'b1, 1'b0, 1'b0, a2, w777, z, z, z, 1'b1, a2, w777, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t2 wait",   1'b1, 1'b0, 1'b0, a1, junk, z, z, z, 1'b1, a2, w777, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t2 ack",    1'b1, 1'b0, 1'b1, a1, junk, z, z, junk, 1'b0, a2, w777, 1'b1, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t2 done",   1'b1, 1'b0, 1'b0, a2, w777, z, z, z, 1'b0, a2, w777, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"t2 idle",   1'b0, 1'b0, 1'b0, z,  z, z, z, z,    1'b0, a2, w777, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"con req",   1'b0, 1'b1, 1'b0, z,  z, a3, cw, z,  1'b1, a3, cw, 1'b0, 1'b0, d1, 1'b0, 1'b0, z});
        vecs.push_back('{"con ack",   1'b0, 1'b1, 1'b1, z,  z, a3, cw, d3, 1'b0, a3, cw, 1'b0, 1'b0, d1, 1'b1, 1'b0, d3});
        vecs.push_back('{"con done",  1'b0, 1'b1, 1'b0, z,  z, a3, cw, z,  1'b0, a3, cw, 1'b0, 1'b0, d1, 1'b0, 1'b0, d3});
        vecs.push_back('{"con idle",  1'b0, 1'b0, 1'b0, z,  z, z, z, z,    1'b0, a3, cw, 1'b0, 1'b0, d1, 1'b0, 1'b0, d3});

        rst = 1'b1;
        cpuREQI = 1'b0; conREQI = 1'b0; busACKI = 1'b0;
        cpuADDRI = '0; cpuDATAI = '0; conADDRI = '0; conDATAI = '0; busDATAI = '0;
        tick();
        tick();
        check("reset busREQO", busREQO, 0);
        check("reset busADDRO", busADDRO, 0);
        check("reset busDATAO", busDATAO, 0);
        check("reset acks", {cpuACKO, conACKO, cpuNXMO, conNXMO}, 0);
        check("reset cpuDATAO", cpuDATAO, 0);
        check("reset conDATAO", conDATAO, 0);
        $display("seq reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cpuREQI  = vecs[i].cpu_req;
            conREQI  = vecs[i].con_req;
            busACKI  = vecs[i].ack;
            cpuADDRI = vecs[i].cpu_addr;
            cpuDATAI = vecs[i].cpu_wd;
            conADDRI = vecs[i].con_addr;
            conDATAI = vecs[i].con_wd;
            busDATAI = vecs[i].bus_rd;
            tick();
            check({vecs[i].name, " busREQO"}, busREQO, vecs[i].e_busreq);
            check({vecs[i].name, " busADDRO"}, busADDRO, vecs[i].e_busaddr);
            check({vecs[i].name, " busDATAO"}, busDATAO, vecs[i].e_busdata);
            check({vecs[i].name, " cpuACKO"}, cpuACKO, vecs[i].e_cpuack);
            check({vecs[i].name, " cpuNXMO"}, cpuNXMO, vecs[i].e_cpunxm);
            check({vecs[i].name, " cpuDATAO"}, cpuDATAO, vecs[i].e_cpudata);
            check({vecs[i].name, " conACKO"}, conACKO, vecs[i].e_conack);
            check({vecs[i].name, " conNXMO"}, conNXMO, vecs[i].e_connxm);
            check({vecs[i].name, " conDATAO"}, conDATAO, vecs[i].e_condata);
            $display("vec %0d %s", i, vecs[i].name);
        end
        busACKI = 1'b0;

        // Console read with no MEM response: NXM at cycle 17 (16th edge after REQ).
        cpuREQI = 1'b0; conREQI = 1'b1; conADDRI = a_to;
        ack_e = 0; wait_n = 0; nxm_seen = 1'b0; dat = '1;
        for (int e = 1; e <= 40 && ack_e == 0; e++) begin
            tick();
            if (busREQO) wait_n++;
            if (conACKO) begin
                ack_e    = e;
                nxm_seen = conNXMO;
                dat      = conDATAO;
            end
        end
        check("t3 ack edge", 36'(ack_e), 36'd16);
        check("t3 conNXMO", {35'd0, nxm_seen}, 36'd1);
        check("t3 conDATAO", dat, 36'd0);
        check("t3 wait cycles", 36'(wait_n), 36'd15);
        check("t3 cpuDATAO", cpuDATAO, d1);
        tick();
        conREQI = 1'b0;
        tick();
        tick();
        check("t3 idle busREQO", busREQO, 0);
        $display("seq t3 timeout: ack edge %0d", ack_e);

        // CPU drops REQ in the middle of WAIT; the issued cycle still completes once.
        cpuREQI = 1'b1; cpuADDRI = a1; busACKI = 1'b0;
        tick();
        cpuREQI = 1'b0;
        tick();
        tick();
        busACKI = 1'b1; busDATAI = d6;
        tick();
        busACKI = 1'b0;
        check("t6 cpuACKO", cpuACKO, 1);
        check("t6 cpuNXMO", cpuNXMO, 0);
        check("t6 cpuDATAO", cpuDATAO, d6);
        n = 0;
        for (int e = 0; e < 8; e++) begin
            tick();
            if (cpuACKO) n++;
            if (busREQO) n++;
        end
        check("t6 no regrant", 36'(n), 36'd0);
        $display("seq t6 drop mid-wait");

        // Reset during the second WAIT cycle aborts the bus cycle.
        cpuREQI = 1'b1; cpuADDRI = a1; busACKI = 1'b0;
        tick();
        tick();
        check("t5 in wait", busREQO, 1);
        rst = 1'b1;
        cpuREQI = 1'b0;
        tick();
        rst = 1'b0;
        check("t5 busREQO", busREQO, 0);
        check("t5 cpuACKO", cpuACKO, 0);
        check("t5 cpuNXMO", cpuNXMO, 0);
        check("t5 cpuDATAO", cpuDATAO, 0);
        check("t5 busADDRO", busADDRO, 0);
        n = 0;
        for (int e = 0; e < 20; e++) begin
            tick();
            if (cpuACKO) n++;
            if (busREQO) n++;
        end
        check("t5 no late ack", 36'(n), 36'd0);
        $display("seq t5 reset mid-wait");

        // Ties: last grant is console after reset.
        run_req("tie1", 1'b1, 1'b1, RR ? 2 : 5, RR ? 5 : 2);
        run_req("cpu only", 1'b1, 1'b0, 2, 0);
        run_req("tie2", 1'b1, 1'b1, 5, 2);
        run_req("con only", 1'b0, 1'b1, 0, 2);
        run_req("tie3", 1'b1, 1'b1, RR ? 2 : 5, RR ? 5 : 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
